// File: rtl/vernam_decipher_stream.sv
// Streaming mod-26 letter decryptor: a repeating key loaded over its own handshake is
// subtracted from each ciphertext letter; the result leaves through one registered stage.
module vernam_decipher_stream #(
    parameter int KEY_DEPTH = 16,
    parameter int KEY_AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [7:0]        key_char,
    input  logic              key_last,
    output logic              key_err,
    output logic [KEY_AW:0]   key_len,
    output logic              key_loaded,
    input  logic              ct_valid,
    output logic              ct_ready,
    input  logic [7:0]        ciphertext,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [7:0]        Plaintext,
    output logic              pt_err,
    input  logic              rekey
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    function automatic logic is_letter(input logic [7:0] ch);
        return (ch >= 8'h41) && (ch <= 8'h5A);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [KEY_AW-1:0]   wr_ptr_r;
    logic [KEY_AW-1:0]   idx_r;
    logic [4:0]          key_mem_r [KEY_DEPTH];

    logic                key_ok_s;
    logic                key_acc_s;
    logic                key_full_s;
    logic                ct_acc_s;
    logic                ct_letter_s;
    logic                drain_ok_s;
    logic                idx_wrap_s;
    logic                enter_run_s;
    logic [KEY_AW:0]     len_nxt_s;
    logic [5:0]          c_s;
    logic [5:0]          k_s;
    logic [5:0]          p_s;

    assign key_ok_s    = is_letter(key_char);
    assign ct_letter_s = is_letter(ciphertext);
    assign key_acc_s   = key_valid && key_ready;
    assign ct_acc_s    = ct_valid && ct_ready;
    assign key_full_s  = (wr_ptr_r == KEY_AW'(KEY_DEPTH - 1));
    assign drain_ok_s  = !pt_valid || pt_ready;
    assign idx_wrap_s  = ({1'b0, idx_r} == (key_len - {{KEY_AW{1'b0}}, 1'b1}));
    assign enter_run_s = (state_r != S_RUN) && (state_nxt_s == S_RUN);
    // A rejected final character closes the key at the characters already stored.
    assign len_nxt_s   = key_ok_s ? ({1'b0, wr_ptr_r} + {{KEY_AW{1'b0}}, 1'b1})
                                  : {1'b0, wr_ptr_r};

    // Mod-26 subtraction; letter codes 0x41..0x5A carry offset+1 in their low bits.
    always_comb begin
        c_s = ciphertext[5:0] - 6'd1;
        k_s = {1'b0, key_mem_r[idx_r]};
        if (c_s >= k_s) begin
            p_s = c_s - k_s;
        end else begin
            p_s = c_s + 6'd26 - k_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_EMPTY, S_LOAD: begin
                if (rekey) begin
                    state_nxt_s = S_EMPTY;
                end else if (key_acc_s && key_ok_s) begin
                    state_nxt_s = (key_last || key_full_s) ? S_RUN : S_LOAD;
                end else if (key_acc_s && key_last) begin
                    state_nxt_s = (wr_ptr_r != {KEY_AW{1'b0}}) ? S_RUN : S_EMPTY;
                end else if (key_acc_s) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_RUN: begin
                if (rekey && drain_ok_s) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: state_nxt_s = S_EMPTY;
        endcase
    end

    // Handshake outputs; rekey blocks both key and ciphertext acceptance.
    always_comb begin
        key_ready  = 1'b0;
        ct_ready   = 1'b0;
        key_loaded = 1'b0;
        case (state_r)
            S_EMPTY, S_LOAD: key_ready = !rekey;
            S_RUN: begin
                ct_ready   = !rekey && drain_ok_s;
                key_loaded = 1'b1;
            end
            default: begin
                key_ready  = 1'b0;
                ct_ready   = 1'b0;
                key_loaded = 1'b0;
            end
        endcase
    end

    // Key storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (key_acc_s && key_ok_s) begin
            key_mem_r[wr_ptr_r] <= key_char[4:0] - 5'd1;
        end
    end

    // Key pointers, key length, error pulse and output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {KEY_AW{1'b0}};
            idx_r     <= {KEY_AW{1'b0}};
            key_len   <= {(KEY_AW+1){1'b0}};
            key_err   <= 1'b0;
            pt_valid  <= 1'b0;
            Plaintext <= 8'h00;
            pt_err    <= 1'b0;
        end else begin
            key_err <= key_acc_s && !key_ok_s;
            if (state_r != S_RUN) begin
                if (rekey) begin
                    wr_ptr_r <= {KEY_AW{1'b0}};
                end else if (key_acc_s && key_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + {{(KEY_AW-1){1'b0}}, 1'b1};
                end
                if (enter_run_s) begin
                    key_len <= len_nxt_s;
                    idx_r   <= {KEY_AW{1'b0}};
                end
            end else if (rekey && drain_ok_s) begin
                wr_ptr_r <= {KEY_AW{1'b0}};
                idx_r    <= {KEY_AW{1'b0}};
                key_len  <= {(KEY_AW+1){1'b0}};
            end else if (ct_acc_s && ct_letter_s) begin
                idx_r <= idx_wrap_s ? {KEY_AW{1'b0}} : (idx_r + {{(KEY_AW-1){1'b0}}, 1'b1});
            end

            if (ct_acc_s) begin
                pt_valid <= 1'b1;
                if (ct_letter_s) begin
                    Plaintext <= 8'h41 + {2'b00, p_s};
                    pt_err    <= 1'b0;
                end else begin
                    Plaintext <= ciphertext;
                    pt_err    <= 1'b1;
                end
            end else if (pt_ready) begin
                pt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vernam_decipher_stream.sv
// Directed bench for vernam_decipher_stream with a 4-character key store; expected
// plaintext values are worked out by hand from (c - k) mod 26.
module tb_vernam_decipher_stream;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_char;
    logic       key_last;
    logic       key_err;
    logic [2:0] key_len;
    logic       key_loaded;
    logic       ct_valid;
    logic       ct_ready;
    logic [7:0] ciphertext;
    logic       pt_valid;
    logic       pt_ready;
    logic [7:0] Plaintext;
    logic       pt_err;
    logic       rekey;

    int n_cmp = 0;
    int n_err = 0;

    vernam_decipher_stream #(.KEY_DEPTH(4), .KEY_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready), .key_char(key_char),
        .key_last(key_last), .key_err(key_err), .key_len(key_len),
        .key_loaded(key_loaded),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ciphertext(ciphertext),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .Plaintext(Plaintext),
        .pt_err(pt_err), .rekey(rekey)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] ch, input logic last);
        key_valid = 1'b1;
        key_char  = ch;
        key_last  = last;
        tick();
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    task automatic send_ct(input string tag, input logic [7:0] ch,
                           input logic [7:0] exp_pt, input logic exp_err);
        ct_valid   = 1'b1;
        ciphertext = ch;
        #1;
        chk({tag, "_ctrdy"}, 32'(ct_ready), 32'd1);
        tick();
        chk({tag, "_vld"}, 32'(pt_valid), 32'd1);
        chk({tag, "_pt"}, 32'(Plaintext), 32'(exp_pt));
        chk({tag, "_err"}, 32'(pt_err), 32'(exp_err));
    endtask

    task automatic do_rekey();
        ct_valid = 1'b0;
        pt_ready = 1'b1;
        tick();
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        chk("rekey_loaded", 32'(key_loaded), 32'd0);
        chk("rekey_len", 32'(key_len), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_char = 8'h00; key_last = 1'b0;
        ct_valid = 1'b0; ciphertext = 8'h00; pt_ready = 1'b1; rekey = 1'b0;
        #1;
        chk("rst_len", 32'(key_len), 32'd0);
        chk("rst_loaded", 32'(key_loaded), 32'd0);
        chk("rst_ptvld", 32'(pt_valid), 32'd0);
        chk("rst_pt", 32'(Plaintext), 32'h00);
        chk("rst_pterr", 32'(pt_err), 32'd0);
        chk("rst_keyerr", 32'(key_err), 32'd0);
        chk("rst_keyrdy", 32'(key_ready), 32'd1);
        chk("rst_ctrdy", 32'(ct_ready), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        // Basic: key KEY, "RIJVS" -> "HELLO"
        send_key("K", 1'b0);
        send_key("E", 1'b0);
        chk("kld_notyet", 32'(key_loaded), 32'd0);
        send_key("Y", 1'b1);
        chk("kld_len", 32'(key_len), 32'd3);
        chk("kld_loaded", 32'(key_loaded), 32'd1);
        chk("kld_keyrdy", 32'(key_ready), 32'd0);
        chk("kld_keyerr", 32'(key_err), 32'd0);
        send_ct("b0", "R", "H", 1'b0);
        send_ct("b1", "I", "E", 1'b0);
        send_ct("b2", "J", "L", 1'b0);
        send_ct("b3", "V", "L", 1'b0);
        send_ct("b4", "S", "O", 1'b0);
        ct_valid = 1'b0;
        tick();
        chk("b_drain", 32'(pt_valid), 32'd0);
        do_rekey();

        // Mod-26 wrap with key Z
        send_key("Z", 1'b1);
        chk("z_len", 32'(key_len), 32'd1);
        send_ct("z0", "A", "B", 1'b0);
        send_ct("z1", "Z", "A", 1'b0);
        do_rekey();

        // Non-letter pass-through and backpressure
        send_key("K", 1'b0);
        send_key("E", 1'b0);
        send_key("Y", 1'b1);
        send_ct("n0", "R", "H", 1'b0);
        send_ct("n1", 8'h20, 8'h20, 1'b1);
        send_ct("n2", "I", "E", 1'b0);
        pt_ready   = 1'b0;
        ciphertext = "J";
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ctrdy", 32'(ct_ready), 32'd0);
            chk("bp_vld", 32'(pt_valid), 32'd1);
            chk("bp_pt", 32'(Plaintext), 32'(8'h45));
            chk("bp_err", 32'(pt_err), 32'd0);
            tick();
        end
        pt_ready = 1'b1;
        send_ct("n3", "J", "L", 1'b0);
        send_ct("n4", "V", "L", 1'b0);
        send_ct("n5", "S", "O", 1'b0);

        // rekey blocked while output is held
        ct_valid = 1'b0;
        pt_ready = 1'b0;
        rekey    = 1'b1;
        #1;
        chk("rk_ctrdy", 32'(ct_ready), 32'd0);
        tick();
        chk("rk_hold_loaded", 32'(key_loaded), 32'd1);
        chk("rk_hold_pt", 32'(Plaintext), 32'(8'h4F));
        tick();
        chk("rk_hold2_loaded", 32'(key_loaded), 32'd1);
        chk("rk_hold2_vld", 32'(pt_valid), 32'd1);
        pt_ready = 1'b1;
        tick();
        rekey = 1'b0;
        chk("rk_loaded", 32'(key_loaded), 32'd0);
        chk("rk_len", 32'(key_len), 32'd0);
        chk("rk_vld", 32'(pt_valid), 32'd0);

        // Key limits: A,B,1,C,D fills the 4-entry store; E is refused
        send_key("A", 1'b0);
        send_key("B", 1'b0);
        chk("lim_noerr", 32'(key_err), 32'd0);
        send_key("1", 1'b0);
        chk("lim_err", 32'(key_err), 32'd1);
        chk("lim_err_loaded", 32'(key_loaded), 32'd0);
        send_key("C", 1'b0);
        chk("lim_err_pulse", 32'(key_err), 32'd0);
        send_key("D", 1'b0);
        chk("lim_loaded", 32'(key_loaded), 32'd1);
        chk("lim_len", 32'(key_len), 32'd4);
        key_valid = 1'b1;
        key_char  = "E";
        #1;
        chk("lim_E_rdy", 32'(key_ready), 32'd0);
        tick();
        key_valid = 1'b0;
        chk("lim_E_len", 32'(key_len), 32'd4);
        send_ct("l0", "B", "B", 1'b0);
        send_ct("l1", "B", "A", 1'b0);
        send_ct("l2", "B", "Z", 1'b0);
        send_ct("l3", "B", "Y", 1'b0);
        send_ct("l4", "B", "B", 1'b0);
        do_rekey();

        // Single invalid character with key_last stays empty
        send_key("1", 1'b1);
        chk("inv_err", 32'(key_err), 32'd1);
        chk("inv_loaded", 32'(key_loaded), 32'd0);
        chk("inv_len", 32'(key_len), 32'd0);
        chk("inv_keyrdy", 32'(key_ready), 32'd1);

        // rekey in S_LOAD wins over a key beat and discards the partial key
        send_key("A", 1'b0);
        key_valid = 1'b1;
        key_char  = "B";
        rekey     = 1'b1;
        #1;
        chk("ld_rk_keyrdy", 32'(key_ready), 32'd0);
        tick();
        key_valid = 1'b0;
        rekey     = 1'b0;
        send_key("C", 1'b1);
        chk("ld_rk_len", 32'(key_len), 32'd1);
        send_ct("r0", "C", "A", 1'b0);
        send_ct("r1", "D", "B", 1'b0);
        do_rekey();

        // Asynchronous reset mid-stream
        send_key("K", 1'b1);
        send_ct("a0", "R", "H", 1'b0);
        ct_valid = 1'b0;
        pt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(pt_valid), 32'd0);
        chk("arst_loaded", 32'(key_loaded), 32'd0);
        chk("arst_len", 32'(key_len), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_after_keyrdy", 32'(key_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
